// File: rtl/in_buffer_if.sv
// Host-side word bus and 3DES-core block handshake for the input packer.
interface in_buffer_if #(
    parameter int DEPTH = 24,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic [31:0]   data_in;
    logic          data_in_write;
    logic          block_read;
    logic          clear;
    logic [63:0]   data_out;
    logic          block_valid;
    logic [CW-1:0] count;
    logic          full;
    logic          overflow;
    logic          underflow;

    modport master (
        output data_in, data_in_write, block_read, clear,
        input  data_out, block_valid, count, full, overflow, underflow
    );

    modport slave (
        input  data_in, data_in_write, block_read, clear,
        output data_out, block_valid, count, full, overflow, underflow
    );
endinterface

// File: rtl/in_buffer.sv
// Circular 32-bit word FIFO that packs word pairs into 64-bit blocks;
// first word received lands in block bits [31:0].
module in_buffer #(
    parameter int DEPTH = 24
) (
    input  logic         clk,
    input  logic         rst,
    in_buffer_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_hi;
    logic [CW-1:0] count_q;
    logic          ovf_q, udf_q;
    logic          valid, pop, push;

    assign valid = (count_q >= CW'(2));
    assign pop   = bus.block_read & valid;
    // A same-cycle pop frees a slot, so a write while full still lands.
    assign push  = bus.data_in_write & ((count_q < CW'(DEPTH)) | pop);
    assign rd_hi = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else if (bus.clear) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.data_in;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= (rd_ptr >= PW'(DEPTH - 2)) ? '0 : rd_ptr + PW'(2);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - CW'(2);
                2'b11:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (bus.data_in_write & ~push) ovf_q <= 1'b1;
            if (bus.block_read & ~valid)   udf_q <= 1'b1;
        end
    end

    assign bus.data_out    = valid ? {mem[rd_hi], mem[rd_ptr]} : 64'h0;
    assign bus.block_valid = valid;
    assign bus.count       = count_q;
    assign bus.full        = (count_q == CW'(DEPTH));
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = udf_q;
endmodule

// File: tb/tb_in_buffer.sv
// Randomized + directed bench for in_buffer against a queue-based word model.
module tb_in_buffer;
    localparam int DEPTH = 24;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    in_buffer_if #(.DEPTH(DEPTH)) bus();
    in_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int pass_cnt = 0;
    int total    = 0;

    logic [31:0] q[$];
    bit m_ovf, m_udf;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] m_block();
        return (q.size() >= 2) ? {q[1], q[0]} : 64'h0;
    endfunction

    // Queue model: a block is the two oldest words; pop before push frees room.
    task automatic model(input bit w, input logic [31:0] d, input bit r, input bit c);
        bit pop;
        if (c) begin
            q.delete(); m_ovf = 0; m_udf = 0;
            return;
        end
        pop = r && (q.size() >= 2);
        if (r && !pop) m_udf = 1;
        if (pop) begin void'(q.pop_front()); void'(q.pop_front()); end
        if (w) begin
            if (q.size() < DEPTH) q.push_back(d);
            else m_ovf = 1;
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("data_out",    bus.data_out,           m_block());
            chk("block_valid", 64'(bus.block_valid),   64'(q.size() >= 2));
            chk("count",       64'(bus.count),         64'(q.size()));
            chk("full",        64'(bus.full),          64'(q.size() == DEPTH));
            chk("overflow",    64'(bus.overflow),      64'(m_ovf));
            chk("underflow",   64'(bus.underflow),     64'(m_udf));
        end
    end

    task automatic step(input bit w, input logic [31:0] d, input bit r, input bit c);
        bus.data_in = d; bus.data_in_write = w; bus.block_read = r; bus.clear = c;
        @(posedge clk);
        model(w, d, r, c);
        @(negedge clk);
        bus.data_in_write = 0; bus.block_read = 0; bus.clear = 0;
    endtask

    initial begin
        rst = 1'b1;
        bus.data_in = '0; bus.data_in_write = 0; bus.block_read = 0; bus.clear = 0;
        repeat (2) @(negedge clk);
        chk("rst_data_out", bus.data_out, 64'h0);
        chk("rst_valid", 64'(bus.block_valid), 64'h0);
        chk("rst_count", 64'(bus.count), 64'h0);
        chk("rst_full", 64'(bus.full), 64'h0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // pairing order
        step(1, 32'h01234567, 0, 0);
        step(1, 32'h89ABCDEF, 0, 0);
        chk("t1_count", 64'(bus.count), 64'd2);
        chk("t1_valid", 64'(bus.block_valid), 64'd1);
        chk("t1_block", bus.data_out, 64'h89ABCDEF_01234567);
        step(0, 0, 1, 0);
        chk("t1_empty", bus.data_out, 64'h0);
        chk("t1_count0", 64'(bus.count), 64'd0);

        // fill, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) step(1, 32'(i), 0, 0);
        chk("t2_full", 64'(bus.full), 64'd1);
        step(1, 32'hDEAD, 0, 0);
        chk("t2_ovf", 64'(bus.overflow), 64'd1);
        chk("t2_count", 64'(bus.count), 64'd24);
        for (int i = 0; i < DEPTH / 2; i++) begin
            chk("t2_blk", bus.data_out, {32'(2 * i + 1), 32'(2 * i)});
            step(0, 0, 1, 0);
        end

        // pointer wrap
        for (int i = 0; i < 20; i++) step(1, 32'(1000 + i), 0, 0);
        for (int i = 0; i < 8; i++)  step(0, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 32'(2000 + i), 0, 0);
        chk("t3_count", 64'(bus.count), 64'd14);
        chk("t3_blk", bus.data_out, {32'd1017, 32'd1016});
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
        chk("t3_empty", 64'(bus.count), 64'd0);

        // write while full accepted alongside a pop
        step(0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 32'(3000 + i), 0, 0);
        step(1, 32'hCAFE0001, 1, 0);
        chk("t4_count", 64'(bus.count), 64'd23);
        chk("t4_ovf", 64'(bus.overflow), 64'd0);
        for (int i = 0; i < 11; i++) step(0, 0, 1, 0);
        step(1, 32'hCAFE0002, 0, 0);
        chk("t4_last", bus.data_out, 64'hCAFE0002_CAFE0001);
        step(0, 0, 1, 0);

        // lone word held through an underflow read
        step(1, 32'h5555, 0, 0);
        step(0, 0, 1, 0);
        chk("t5_udf", 64'(bus.underflow), 64'd1);
        chk("t5_count", 64'(bus.count), 64'd1);
        chk("t5_valid", 64'(bus.block_valid), 64'd0);
        step(1, 32'h6666, 0, 0);
        chk("t5_blk", bus.data_out, 64'h00006666_00005555);
        step(0, 0, 1, 0);

        // randomized traffic with write-heavy, balanced and read-heavy phases
        for (int p = 0; p < 3; p++) begin
            for (int n = 0; n < 300; n++) begin
                int wp;
                wp = (p == 0) ? 80 : (p == 1) ? 50 : 25;
                step($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < 45,
                     $urandom_range(0, 199) == 0);
            end
        end

        // clear beats a same-cycle write; async reset mid-cycle
        step(0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 32'(4000 + i), 0, 0);
        step(1, 32'hBEEF, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
        chk("t6_count6", 64'(bus.count), 64'd6);
        chk("t6_ovf1", 64'(bus.overflow), 64'd1);
        step(1, 32'h77, 0, 1);
        chk("t6_count0", 64'(bus.count), 64'd0);
        chk("t6_ovf0", 64'(bus.overflow), 64'd0);
        for (int i = 0; i < 4; i++) step(1, 32'(5000 + i), 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_data", bus.data_out, 64'h0);
        chk("t6_rst_valid", 64'(bus.block_valid), 64'h0);
        chk("t6_rst_count", 64'(bus.count), 64'h0);
        chk("t6_rst_full", 64'(bus.full), 64'h0);
        chk("t6_rst_ovf", 64'(bus.overflow), 64'h0);
        chk("t6_rst_udf", 64'(bus.underflow), 64'h0);
        q.delete(); m_ovf = 0; m_udf = 0;
        @(negedge clk);
        rst = 1'b0;
        step(1, 32'hA, 0, 0);
        step(1, 32'hB, 0, 0);
        chk("post_rst_blk", bus.data_out, 64'h0000000B_0000000A);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
